// File: rtl/tvc_cas_loader.sv
// CAS download loader: parses the TVC program header from the data_io byte stream and
// writes the payload into emulated RAM through a small FIFO and a req/ack port.
module tvc_cas_loader #(
    parameter logic [7:0]  CAS_IDX    = 8'd1,
    parameter int unsigned HDR_LEN    = 144,
    parameter logic [15:0] LOAD_ADDR  = 16'h19EF,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_clkref,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_din,
    input  logic        mem_ack,
    output logic [15:0] prog_len,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int unsigned PW  = $clog2(FIFO_DEPTH);
    localparam int unsigned HCW = $clog2(HDR_LEN + 1);

    localparam logic [HCW-1:0] HdrLast  = HCW'(HDR_LEN - 1);
    localparam logic [HCW-1:0] OffLenLo = HCW'(8'h82);
    localparam logic [HCW-1:0] OffLenHi = HCW'(8'h83);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StHeader = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
    localparam logic [2:0] StDrain  = 3'd3;  // download aborted, finishing pending writes
    localparam logic [2:0] StDone   = 3'd4;
    localparam logic [2:0] StErr    = 3'd5;

    logic [2:0]     state_q, state_d;
    logic           dl_q;
    logic [HCW-1:0] hdr_cnt_q, hdr_cnt_d;
    logic [15:0]    prog_len_q, prog_len_d;
    logic [15:0]    pushed_q, pushed_d;
    logic [15:0]    written_q, written_d;
    logic           done_q, done_d;
    logic           error_q, error_d;
    logic           mem_req_q;
    logic [15:0]    mem_addr_q;
    logic [7:0]     mem_din_q;

    logic [7:0]     fifo_q [FIFO_DEPTH];
    logic [PW:0]    wr_ptr_q, rd_ptr_q;
    logic           fifo_empty, fifo_full;
    logic           push, pop, start;
    logic [16:0]    end_addr, push_addr;

    // ioctl_addr is deliberately unused: byte offsets come from the internal counter
    logic           unused_addr;
    assign unused_addr = ^ioctl_addr;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign pop        = mem_req_q && mem_ack;

    // Level start from IDLE; DONE/ERR need a fresh rising edge of the download flag
    assign start = ioctl_download && (ioctl_index == CAS_IDX) &&
                   ((state_q == StIdle) ||
                    (!dl_q && ((state_q == StDone) || (state_q == StErr))));

    assign end_addr  = {1'b0, LOAD_ADDR} + {1'b0, prog_len_d};
    assign push_addr = {1'b0, LOAD_ADDR} + {1'b0, pushed_q};

    // Next-state logic for the download FSM, counters and sticky flags
    always_comb begin
        state_d    = state_q;
        hdr_cnt_d  = hdr_cnt_q;
        prog_len_d = prog_len_q;
        pushed_d   = pushed_q;
        written_d  = written_q + 16'(pop);
        done_d     = done_q;
        error_d    = error_q;
        push       = 1'b0;
        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d    = StHeader;
                    hdr_cnt_d  = '0;
                    prog_len_d = '0;
                    pushed_d   = '0;
                    written_d  = '0;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                end
            end
            StHeader: begin
                if (!ioctl_download) begin
                    state_d = StDrain;
                end else if (ioctl_wr) begin
                    hdr_cnt_d = hdr_cnt_q + 1'b1;
                    if (hdr_cnt_q == OffLenLo) prog_len_d[7:0]  = ioctl_dout;
                    if (hdr_cnt_q == OffLenHi) prog_len_d[15:8] = ioctl_dout;
                    if (hdr_cnt_q == HdrLast) begin
                        if (prog_len_d == 16'h0000) begin
                            state_d = StDone;
                            done_d  = 1'b1;
                        end else begin
                            state_d = StData;
                            if (end_addr > 17'h10000) error_d = 1'b1;
                        end
                    end
                end
            end
            StData: begin
                if (ioctl_wr && (pushed_q < prog_len_q)) begin
                    if (fifo_full && !pop) begin
                        error_d = 1'b1;  // overrun: byte lost
                    end else begin
                        pushed_d = pushed_q + 16'd1;
                        push     = !push_addr[16];  // beyond 0xFFFF: discard, never wrap
                    end
                end
                if ((written_q == prog_len_q) && !error_q) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else if (!ioctl_download && ((pushed_q < prog_len_q) || error_q)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (fifo_empty && !mem_req_q) begin
                    state_d = StErr;
                    error_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM and counter state
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= StIdle;
            dl_q       <= 1'b0;
            hdr_cnt_q  <= '0;
            prog_len_q <= '0;
            pushed_q   <= '0;
            written_q  <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dl_q       <= ioctl_download;
            hdr_cnt_q  <= hdr_cnt_d;
            prog_len_q <= prog_len_d;
            pushed_q   <= pushed_d;
            written_q  <= written_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    // FIFO pointers; pop and push may both happen on a full FIFO
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // FIFO storage, no reset needed
    always_ff @(posedge clk_sys) begin
        if (push) fifo_q[wr_ptr_q[PW-1:0]] <= ioctl_dout;
    end

    // Memory request: capture FIFO head while idle, hold until ack
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
        end else if (pop) begin
            mem_req_q <= 1'b0;
        end else if (!mem_req_q && !fifo_empty) begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= LOAD_ADDR + written_q;
            mem_din_q  <= fifo_q[rd_ptr_q[PW-1:0]];
        end
    end

    assign ioctl_clkref = (state_q == StData) ? ~fifo_full : 1'b1;
    assign mem_req      = mem_req_q;
    assign mem_addr     = mem_addr_q;
    assign mem_din      = mem_din_q;
    assign prog_len     = prog_len_q;
    assign busy         = (state_q == StHeader) || (state_q == StData) || (state_q == StDrain);
    assign done         = done_q;
    assign error        = error_q;

endmodule

// File: tb/tb_tvc_cas_loader.sv
// Directed bench for tvc_cas_loader. A second instance with a high load address covers
// the 64 KiB boundary without streaming ~58k bytes; sel routes the shared stimulus.
module tb_tvc_cas_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = 8'd0;
    logic        mem_ack = 1'b0;
    logic        sel = 1'b0;

    logic        clkref_a, req_a, busy_a, done_a, err_a;
    logic        clkref_b, req_b, busy_b, done_b, err_b;
    logic [15:0] addr_a, addr_b, len_a, len_b;
    logic [7:0]  din_a, din_b;

    logic        ioctl_clkref, mem_req, busy, done, error;
    logic [15:0] mem_addr, prog_len;
    logic [7:0]  mem_din;

    int          n_checks = 0;
    int          n_fail = 0;
    int          ack_dly = 0;
    int          req_age = 0;
    logic [15:0] log_addr [$];
    logic [7:0]  log_data [$];

    always #5 clk = ~clk;

    tvc_cas_loader u_dut (
        .clk_sys(clk), .reset(reset), .ioctl_download(ioctl_download & ~sel),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_clkref(clkref_a), .mem_req(req_a),
        .mem_addr(addr_a), .mem_din(din_a), .mem_ack(mem_ack & ~sel), .prog_len(len_a),
        .busy(busy_a), .done(done_a), .error(err_a)
    );

    tvc_cas_loader #(.LOAD_ADDR(16'hFFF0)) u_wrap (
        .clk_sys(clk), .reset(reset), .ioctl_download(ioctl_download & sel),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_clkref(clkref_b), .mem_req(req_b),
        .mem_addr(addr_b), .mem_din(din_b), .mem_ack(mem_ack & sel), .prog_len(len_b),
        .busy(busy_b), .done(done_b), .error(err_b)
    );

    assign ioctl_clkref = sel ? clkref_b : clkref_a;
    assign mem_req      = sel ? req_b : req_a;
    assign mem_addr     = sel ? addr_b : addr_a;
    assign mem_din      = sel ? din_b : din_a;
    assign prog_len     = sel ? len_b : len_a;
    assign busy         = sel ? busy_b : busy_a;
    assign done         = sel ? done_b : done_a;
    assign error        = sel ? err_b : err_a;

    // Memory model: ack ack_dly cycles after the request is seen, logging each write
    always @(posedge clk) begin
        if (mem_req && !mem_ack) begin
            if (req_age >= ack_dly) begin
                mem_ack <= 1'b1;
                req_age <= 0;
                log_addr.push_back(mem_addr);
                log_data.push_back(mem_din);
            end else begin
                req_age <= req_age + 1;
            end
        end else begin
            mem_ack <= 1'b0;
            req_age <= 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        while (!ioctl_clkref && t < 200) begin
            ioctl_wr = 1'b0;
            @(negedge clk);
            t++;
        end
        if (!ioctl_clkref) begin
            n_checks++;
            n_fail++;
            $error("FAIL clkref_wait: observed 0 expected 1 within 200 cycles");
        end
        ioctl_wr   = 1'b1;
        ioctl_dout = b;
        @(negedge clk);
        ioctl_wr   = 1'b0;
        ioctl_addr = ioctl_addr + 25'd1;
    endtask

    task automatic start_dl(input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_addr     = '0;
        ioctl_download = 1'b1;
        @(negedge clk);
    endtask

    task automatic end_dl();
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_header(input logic [15:0] len);
        for (int i = 0; i < 144; i++) begin
            if (i == 8'h82)      send_byte(len[7:0]);
            else if (i == 8'h83) send_byte(len[15:8]);
            else                 send_byte(8'(i));
        end
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int t = 0;
        while (busy && t < bound) begin
            @(negedge clk);
            t++;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    initial begin
        logic [7:0] p2 [16];
        int         t;
        int         low_addr;
        int         clk_low;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_clkref", {31'd0, ioctl_clkref}, 32'd1);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_len", {16'd0, prog_len}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // 1) three-byte program, ack one cycle after request
        ack_dly = 0;
        clear_log();
        start_dl(8'd1);
        check("t1_busy", {31'd0, busy}, 32'd1);
        send_header(16'h0003);
        check("t1_len", {16'd0, prog_len}, 32'h3);
        send_byte(8'hAA);
        check("t1_lat_req0", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        check("t1_lat_req1", {31'd0, mem_req}, 32'd1);
        check("t1_lat_addr", {16'd0, mem_addr}, 32'h19EF);
        check("t1_lat_din", {24'd0, mem_din}, 32'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        end_dl();
        wait_idle("t1_idle", 100);
        check("t1_done", {31'd0, done}, 32'd1);
        check("t1_error", {31'd0, error}, 32'd0);
        check("t1_nwr", log_addr.size(), 32'd3);
        if (log_addr.size() == 3) begin
            check("t1_a0", {16'd0, log_addr[0]}, 32'h19EF);
            check("t1_d0", {24'd0, log_data[0]}, 32'hAA);
            check("t1_a1", {16'd0, log_addr[1]}, 32'h19F0);
            check("t1_d1", {24'd0, log_data[1]}, 32'hBB);
            check("t1_a2", {16'd0, log_addr[2]}, 32'h19F1);
            check("t1_d2", {24'd0, log_data[2]}, 32'hCC);
        end

        // 2) sixteen bytes, slow memory: back-pressure after four buffered bytes
        ack_dly = 20;
        clear_log();
        for (int i = 0; i < 16; i++) p2[i] = 8'(8'h30 + 8'(i * 7));
        start_dl(8'd1);
        send_header(16'h0010);
        check("t2_clkref_open", {31'd0, ioctl_clkref}, 32'd1);
        for (int i = 0; i < 4; i++) send_byte(p2[i]);
        check("t2_clkref_full", {31'd0, ioctl_clkref}, 32'd0);
        for (int i = 4; i < 16; i++) send_byte(p2[i]);
        end_dl();
        wait_idle("t2_idle", 1000);
        check("t2_done", {31'd0, done}, 32'd1);
        check("t2_error", {31'd0, error}, 32'd0);
        check("t2_nwr", log_addr.size(), 32'd16);
        if (log_addr.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                check("t2_addr", {16'd0, log_addr[i]}, 32'h19EF + 32'(i));
                check("t2_data", {24'd0, log_data[i]}, {24'd0, p2[i]});
            end
        end

        // 3) short file: 5 of 8 payload bytes
        ack_dly = 0;
        clear_log();
        start_dl(8'd1);
        send_header(16'h0008);
        for (int i = 0; i < 5; i++) send_byte(8'(8'h50 + i));
        end_dl();
        wait_idle("t3_idle", 200);
        check("t3_nwr", log_addr.size(), 32'd5);
        check("t3_error", {31'd0, error}, 32'd1);
        check("t3_done", {31'd0, done}, 32'd0);

        // 4a) length that crosses 64 KiB flags error at header end
        clear_log();
        start_dl(8'd1);
        send_header(16'hE700);
        check("t4_len", {16'd0, prog_len}, 32'hE700);
        check("t4_err_hdr", {31'd0, error}, 32'd1);
        check("t4_busy_hdr", {31'd0, busy}, 32'd1);
        end_dl();
        wait_idle("t4_idle", 200);
        check("t4_err_end", {31'd0, error}, 32'd1);

        // 4b) boundary instance at 0xFFF0: 16 writes up to 0xFFFF, rest discarded
        sel = 1'b1;
        @(negedge clk);
        clear_log();
        start_dl(8'd1);
        send_header(16'h0020);
        check("t4b_err_hdr", {31'd0, error}, 32'd1);
        for (int i = 0; i < 32; i++) send_byte(8'(8'h80 + i));
        end_dl();
        wait_idle("t4b_idle", 200);
        check("t4b_nwr", log_addr.size(), 32'd16);
        if (log_addr.size() == 16) begin
            check("t4b_last_addr", {16'd0, log_addr[15]}, 32'hFFFF);
            check("t4b_last_data", {24'd0, log_data[15]}, 32'h8F);
        end
        low_addr = 0;
        foreach (log_addr[i]) if (log_addr[i] < 16'hFFF0) low_addr++;
        check("t4b_no_wrap", low_addr, 32'd0);
        check("t4b_error", {31'd0, error}, 32'd1);
        sel = 1'b0;
        @(negedge clk);

        // 5) reset while a write is pending, then a clean reload
        ack_dly = 20;
        clear_log();
        start_dl(8'd1);
        send_header(16'h0008);
        for (int i = 0; i < 3; i++) send_byte(8'(8'h60 + i));
        t = 0;
        while (!mem_req && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("t5_req_seen", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        ioctl_download = 1'b0;
        @(negedge clk);
        check("t5_rst_req", {31'd0, mem_req}, 32'd0);
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        check("t5_rst_done", {31'd0, done}, 32'd0);
        check("t5_rst_clkref", {31'd0, ioctl_clkref}, 32'd1);
        reset = 1'b0;
        ack_dly = 0;
        @(negedge clk);
        clear_log();
        start_dl(8'd1);
        send_header(16'h0002);
        send_byte(8'h11);
        send_byte(8'h22);
        end_dl();
        wait_idle("t5_idle", 100);
        check("t5_done", {31'd0, done}, 32'd1);
        check("t5_nwr", log_addr.size(), 32'd2);
        if (log_addr.size() == 2) begin
            check("t5_a0", {16'd0, log_addr[0]}, 32'h19EF);
            check("t5_d0", {24'd0, log_data[0]}, 32'h11);
            check("t5_a1", {16'd0, log_addr[1]}, 32'h19F0);
            check("t5_d1", {24'd0, log_data[1]}, 32'h22);
        end

        // 6) ROM download on index 0 is ignored
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        clear_log();
        clk_low = 0;
        start_dl(8'd0);
        for (int i = 0; i < 256; i++) begin
            send_byte(8'(i));
            if (!ioctl_clkref) clk_low++;
        end
        end_dl();
        repeat (4) @(negedge clk);
        check("t6_nwr", log_addr.size(), 32'd0);
        check("t6_clkref_low", clk_low, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_len", {16'd0, prog_len}, 32'd0);
        check("t6_done", {31'd0, done}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
